// File: rtl/parking_pkg.sv
// Shared types and sensor-pattern constants for the parking-lot occupancy monitor.
package parking_pkg;

    // Per-lane crossing tracker states: entry path EN1..EN3, exit path EX1..EX3.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EN1,
        ST_EN2,
        ST_EN3,
        ST_EX1,
        ST_EX2,
        ST_EX3,
        ST_ABORT
    } lane_state_t;

    // Synchronised sensor pattern, packed as {A, B}.
    localparam logic [1:0] AB_CLR = 2'b00;
    localparam logic [1:0] AB_A   = 2'b10;
    localparam logic [1:0] AB_AB  = 2'b11;
    localparam logic [1:0] AB_B   = 2'b01;

endpackage

// File: rtl/lane_fsm.sv
// One lane's crossing recogniser: accepts only complete 4-phase entry/exit sequences.
module lane_fsm
    import parking_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a_s,
    input  logic b_s,
    output logic enter,
    output logic exit,
    output logic seq_error,
    output logic enter_nxt,
    output logic exit_nxt
);

    lane_state_t state_q, state_d;
    logic        enter_q, enter_d;
    logic        exit_q, exit_d;
    logic        err_q, err_d;
    logic [1:0]  ab;

    assign ab = {a_s, b_s};

    // State and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
            err_q   <= err_d;
        end
    end

    // Next-state decode; an illegal jump enters ABORT and raises a one-cycle error.
    always_comb begin
        state_d = state_q;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ab == AB_A)       state_d = ST_EN1;
                else if (ab == AB_B)  state_d = ST_EX1;
                else if (ab == AB_AB) begin state_d = ST_ABORT; err_d = 1'b1; end
            end
            ST_EN1: begin
                if (ab == AB_AB)       state_d = ST_EN2;
                else if (ab == AB_CLR) state_d = ST_IDLE;
                else if (ab == AB_B)   begin state_d = ST_ABORT; err_d = 1'b1; end
            end
            ST_EN2: begin
                if (ab == AB_B)        state_d = ST_EN3;
                else if (ab == AB_A)   state_d = ST_EN1;
                else if (ab == AB_CLR) begin state_d = ST_ABORT; err_d = 1'b1; end
            end
            ST_EN3: begin
                if (ab == AB_CLR)     begin state_d = ST_IDLE; enter_d = 1'b1; end
                else if (ab == AB_AB) state_d = ST_EN2;
                else if (ab == AB_A)  begin state_d = ST_ABORT; err_d = 1'b1; end
            end
            ST_EX1: begin
                if (ab == AB_AB)       state_d = ST_EX2;
                else if (ab == AB_CLR) state_d = ST_IDLE;
                else if (ab == AB_A)   begin state_d = ST_ABORT; err_d = 1'b1; end
            end
            ST_EX2: begin
                if (ab == AB_A)        state_d = ST_EX3;
                else if (ab == AB_B)   state_d = ST_EX1;
                else if (ab == AB_CLR) begin state_d = ST_ABORT; err_d = 1'b1; end
            end
            ST_EX3: begin
                if (ab == AB_CLR)     begin state_d = ST_IDLE; exit_d = 1'b1; end
                else if (ab == AB_AB) state_d = ST_EX2;
                else if (ab == AB_B)  begin state_d = ST_ABORT; err_d = 1'b1; end
            end
            ST_ABORT: begin
                if (ab == AB_CLR) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter     = enter_q;
    assign exit      = exit_q;
    assign seq_error = err_q;
    assign enter_nxt = enter_d;
    assign exit_nxt  = exit_d;

endmodule

// File: rtl/parking_lot_monitor.sv
// Multi-lane occupancy tracker: sensor synchronisers, per-lane FSMs, saturating counter.
module parking_lot_monitor
    import parking_pkg::*;
#(
    parameter  int NUM_LANES   = 2,
    parameter  int CAPACITY    = 25,
    parameter  int SYNC_STAGES = 2,
    localparam int CW          = $clog2(CAPACITY + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] A,
    input  logic [NUM_LANES-1:0] B,
    output logic [NUM_LANES-1:0] enter,
    output logic [NUM_LANES-1:0] exit,
    output logic [NUM_LANES-1:0] seq_error,
    output logic [CW-1:0]        count,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic        [CW-1:0] CAP_U = CW'(CAPACITY);
    localparam logic signed [CW+1:0] CAP_S = (CW + 2)'(CAPACITY);

    logic [NUM_LANES-1:0] a_sync_q [SYNC_STAGES];
    logic [NUM_LANES-1:0] b_sync_q [SYNC_STAGES];
    logic [NUM_LANES-1:0] enter_nxt, exit_nxt;

    logic        [CW+1:0] n_en, n_ex;
    logic signed [CW+1:0] delta, sum_s;
    logic        [CW-1:0] count_q, count_d;
    logic                 ovf_q, ovf_d, unf_q, unf_d;

    // Multi-flop synchroniser for the asynchronous beam inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                a_sync_q[k] <= '0;
                b_sync_q[k] <= '0;
            end
        end else begin
            a_sync_q[0] <= A;
            b_sync_q[0] <= B;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                a_sync_q[k] <= a_sync_q[k-1];
                b_sync_q[k] <= b_sync_q[k-1];
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_fsm u_lane (
            .clk       (clk),
            .reset     (reset),
            .a_s       (a_sync_q[SYNC_STAGES-1][g]),
            .b_s       (b_sync_q[SYNC_STAGES-1][g]),
            .enter     (enter[g]),
            .exit      (exit[g]),
            .seq_error (seq_error[g]),
            .enter_nxt (enter_nxt[g]),
            .exit_nxt  (exit_nxt[g])
        );
    end

    // Net change from this edge's completed crossings, clamped to [0, CAPACITY].
    always_comb begin
        n_en = '0;
        n_ex = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            n_en = n_en + {{(CW + 1){1'b0}}, enter_nxt[i]};
            n_ex = n_ex + {{(CW + 1){1'b0}}, exit_nxt[i]};
        end
        delta   = signed'(n_en - n_ex);
        sum_s   = signed'({2'b00, count_q}) + delta;
        count_d = sum_s[CW-1:0];
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (sum_s > CAP_S) begin
            count_d = CAP_U;
            ovf_d   = 1'b1;
        end else if (sum_s[CW+1]) begin
            count_d = '0;
            unf_d   = 1'b1;
        end
    end

    // Occupancy register and clamp flags, updated on the same edge as the lane pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign full      = (count_q == CAP_U);
    assign empty     = (count_q == '0);

endmodule

// File: tb/tb_parking_lot_monitor.sv
// Self-checking bench: directed scenarios plus random sensor walks against a position-based model.
module tb_parking_lot_monitor;

    localparam int NL  = 2;
    localparam int CAP = 3;
    localparam int SS  = 2;
    localparam int CW  = $clog2(CAP + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NL-1:0] A = '0;
    logic [NL-1:0] B = '0;
    logic [NL-1:0] enter, exit, seq_error;
    logic [CW-1:0] count;
    logic          full, empty, overflow, underflow;

    int nchecks = 0;
    int nerr    = 0;
    bit cmp_en  = 1'b0;

    parking_lot_monitor #(.NUM_LANES(NL), .CAPACITY(CAP), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .enter     (enter),
        .exit      (exit),
        .seq_error (seq_error),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: each lane is a signed position along its track
    // (+1..+3 entering, -1..-3 exiting, 0 idle) that may only move one step.
    logic [1:0]    m_sync [NL][SS];
    int            m_pos  [NL];
    bit            m_abort[NL];
    int            m_cnt = 0;
    bit   [NL-1:0] m_en = '0, m_ex = '0, m_er = '0;
    bit            m_ov = 1'b0, m_un = 1'b0;

    function automatic int mag(input int dir, input logic [1:0] v);
        if (v == 2'b00) return 0;
        if (v == 2'b11) return 2;
        if (dir > 0) return (v == 2'b10) ? 1 : 3;
        return (v == 2'b01) ? 1 : 3;
    endfunction

    always @(posedge clk) begin : model
        int d, dir, cur, m, nc;
        logic [1:0] s;
        m_en = '0; m_ex = '0; m_er = '0; m_ov = 1'b0; m_un = 1'b0;
        if (reset) begin
            m_cnt = 0;
            for (int l = 0; l < NL; l++) begin
                m_pos[l] = 0; m_abort[l] = 1'b0;
                for (int k = 0; k < SS; k++) m_sync[l][k] = 2'b00;
            end
        end else begin
            d = 0;
            for (int l = 0; l < NL; l++) begin
                s = m_sync[l][SS-1];
                if (m_abort[l]) begin
                    if (s == 2'b00) m_abort[l] = 1'b0;
                end else if (m_pos[l] == 0) begin
                    if (s == 2'b10) m_pos[l] = 1;
                    else if (s == 2'b01) m_pos[l] = -1;
                    else if (s == 2'b11) begin m_abort[l] = 1'b1; m_er[l] = 1'b1; end
                end else begin
                    dir = (m_pos[l] > 0) ? 1 : -1;
                    cur = (m_pos[l] > 0) ? m_pos[l] : -m_pos[l];
                    m   = mag(dir, s);
                    if (m == cur) begin
                        // holding position
                    end else if (m == 0 && cur == 3) begin
                        m_pos[l] = 0;
                        if (dir > 0) begin m_en[l] = 1'b1; d++; end
                        else begin m_ex[l] = 1'b1; d--; end
                    end else if (m == 0 && cur == 1) begin
                        m_pos[l] = 0;
                    end else if (m != 0 && (m - cur == 1 || cur - m == 1)) begin
                        m_pos[l] = dir * m;
                    end else begin
                        m_pos[l] = 0; m_abort[l] = 1'b1; m_er[l] = 1'b1;
                    end
                end
                for (int k = SS - 1; k > 0; k--) m_sync[l][k] = m_sync[l][k-1];
                m_sync[l][0] = {A[l], B[l]};
            end
            nc = m_cnt + d;
            if (nc > CAP) begin m_cnt = CAP; m_ov = 1'b1; end
            else if (nc < 0) begin m_cnt = 0; m_un = 1'b1; end
            else m_cnt = nc;
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("count", int'(count), m_cnt);
            chk("enter", int'(enter), int'(m_en));
            chk("exit", int'(exit), int'(m_ex));
            chk("seq_error", int'(seq_error), int'(m_er));
            chk("overflow", int'(overflow), int'(m_ov));
            chk("underflow", int'(underflow), int'(m_un));
            chk("full", int'(full), int'(m_cnt == CAP));
            chk("empty", int'(empty), int'(m_cnt == 0));
        end
    end

    task automatic set_ab(input int l, input logic [1:0] ab, input int n);
        A[l] = ab[1];
        B[l] = ab[0];
        repeat (n) @(negedge clk);
    endtask

    task automatic both(input logic [1:0] ab0, input logic [1:0] ab1, input int n);
        A = {ab1[1], ab0[1]};
        B = {ab1[0], ab0[0]};
        repeat (n) @(negedge clk);
    endtask

    task automatic do_entry(input int l);
        set_ab(l, 2'b10, 2); set_ab(l, 2'b11, 2); set_ab(l, 2'b01, 2); set_ab(l, 2'b00, 5);
    endtask

    task automatic do_exit(input int l);
        set_ab(l, 2'b01, 2); set_ab(l, 2'b11, 2); set_ab(l, 2'b10, 2); set_ab(l, 2'b00, 5);
    endtask

    logic [1:0] ring [4];
    int         idx  [NL];

    initial begin
        int r;
        logic [1:0] v;
        ring[0] = 2'b00; ring[1] = 2'b10; ring[2] = 2'b11; ring[3] = 2'b01;

        @(negedge clk);
        cmp_en = 1'b1;
        chk("pin_rst_count", int'(count), 0);
        chk("pin_rst_empty", int'(empty), 1);
        chk("pin_rst_model", m_cnt, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: entry on lane 0, pulse three clocks after the final 00
        set_ab(0, 2'b10, 2); set_ab(0, 2'b11, 2); set_ab(0, 2'b01, 2); set_ab(0, 2'b00, 2);
        chk("pin_s1_no_early", int'(enter), 0);
        @(negedge clk);
        chk("pin_s1_enter", int'(enter), 1);
        chk("pin_s1_count", int'(count), 1);
        chk("pin_s1_empty", int'(empty), 0);
        chk("pin_s1_model", m_cnt, 1);
        @(negedge clk);
        chk("pin_s1_pulse_end", int'(enter), 0);
        repeat (3) @(negedge clk);

        // 2: back-out on lane 0 ignored; exit on lane 1
        set_ab(0, 2'b10, 2); set_ab(0, 2'b11, 2); set_ab(0, 2'b10, 2); set_ab(0, 2'b00, 5);
        chk("pin_s2_backout", int'(count), 1);
        do_exit(1);
        chk("pin_s2_exit_count", int'(count), 0);
        chk("pin_s2_exit_empty", int'(empty), 1);

        // 3: 00->11 is illegal, and the tail of that sequence is not an entry
        set_ab(0, 2'b11, 3);
        chk("pin_s3_seq_error", int'(seq_error), 1);
        set_ab(0, 2'b01, 2); set_ab(0, 2'b00, 5);
        chk("pin_s3_no_enter", int'(count), 0);
        do_entry(0);
        chk("pin_s3_recover", int'(count), 1);

        // 4: simultaneous entries clamp at capacity; entry+exit net to zero
        do_entry(0);
        chk("pin_s4_count2", int'(count), 2);
        both(2'b10, 2'b10, 2); both(2'b11, 2'b11, 2); both(2'b01, 2'b01, 2); both(2'b00, 2'b00, 3);
        chk("pin_s4_count3", int'(count), 3);
        chk("pin_s4_full", int'(full), 1);
        chk("pin_s4_overflow", int'(overflow), 1);
        chk("pin_s4_model_ov", int'(m_ov), 1);
        @(negedge clk);
        chk("pin_s4_ovf_end", int'(overflow), 0);
        repeat (3) @(negedge clk);
        both(2'b01, 2'b10, 2); both(2'b11, 2'b11, 2); both(2'b10, 2'b01, 2); both(2'b00, 2'b00, 3);
        chk("pin_s4_net_enter", int'(enter), 2);
        chk("pin_s4_net_exit", int'(exit), 1);
        chk("pin_s4_net_count", int'(count), 3);
        chk("pin_s4_net_noflag", int'(overflow | underflow), 0);
        repeat (3) @(negedge clk);

        // 5: exit at zero clamps and flags underflow
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("pin_s5_reset", int'(count), 0);
        set_ab(1, 2'b01, 2); set_ab(1, 2'b11, 2); set_ab(1, 2'b10, 2); set_ab(1, 2'b00, 3);
        chk("pin_s5_exit", int'(exit), 2);
        chk("pin_s5_underflow", int'(underflow), 1);
        chk("pin_s5_count", int'(count), 0);
        repeat (3) @(negedge clk);

        // 6: reset mid-crossing, then a held 11 is illegal from IDLE
        do_entry(0);
        do_entry(0);
        chk("pin_s6_count2", int'(count), 2);
        set_ab(0, 2'b10, 2); set_ab(0, 2'b11, 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("pin_s6_rst_count", int'(count), 0);
        chk("pin_s6_rst_empty", int'(empty), 1);
        chk("pin_s6_rst_pulses", int'({enter, exit, seq_error, overflow, underflow}), 0);
        repeat (3) @(negedge clk);
        chk("pin_s6_seq_error", int'(seq_error), 1);
        set_ab(0, 2'b00, 5);

        // Random ring walks per lane with occasional junk values and rare resets
        idx[0] = 0; idx[1] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int l = 0; l < NL; l++) begin
                r = $urandom_range(0, 99);
                if (r < 40) begin
                    v = ring[idx[l]];
                end else if (r < 95) begin
                    idx[l] = (idx[l] + ((r < 72) ? 1 : 3)) % 4;
                    v = ring[idx[l]];
                end else begin
                    v = 2'($urandom_range(0, 3));
                    for (int j = 0; j < 4; j++) if (ring[j] == v) idx[l] = j;
                end
                A[l] = v[1];
                B[l] = v[0];
            end
            reset = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        A = '0;
        B = '0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
